// File: rtl/thor2023_wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : thor2023_wb_pkg / thor2023_wb_arbiter_if
// Purpose: 128-bit wishbone command/response types and the bundle that
//          connects the cache controllers and the shared master port to the
//          arbiter.
// Ports  : req_i    per-requester command (into arbiter)
//          resp_o   per-requester response (out of arbiter)
//          wbm_req  shared bus command (out of arbiter)
//          wbm_resp shared bus response (into arbiter)
//          grant_o  one-hot grant, busy_o arbiter not idle
// Rev    : 1.0  initial release
// ============================================================================
package thor2023_wb_pkg;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  vadr;
    logic [127:0] data1;
    logic [7:0]   tid;
    logic [3:0]   cid;
  } wb_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    logic [127:0] dat;
    logic [7:0]   tid;
    logic [3:0]   cid;
  } wb_cmd_response128_t;

endpackage

interface thor2023_wb_arbiter_if #(
  parameter int NREQ = 3
) ();

  thor2023_wb_pkg::wb_cmd_request128_t  [NREQ-1:0] req_i;
  thor2023_wb_pkg::wb_cmd_response128_t [NREQ-1:0] resp_o;
  thor2023_wb_pkg::wb_cmd_request128_t             wbm_req;
  thor2023_wb_pkg::wb_cmd_response128_t            wbm_resp;
  logic                                [NREQ-1:0] grant_o;
  logic                                            busy_o;

  // Arbiter side
  modport slave (
    input  req_i, wbm_resp,
    output resp_o, wbm_req, grant_o, busy_o
  );

  // Requesters / bus side
  modport master (
    output req_i, wbm_resp,
    input  resp_o, wbm_req, grant_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/thor2023_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : thor2023_wb_arbiter
// Purpose: Round-robin sharing of one 128-bit wishbone master port between
//          the icache (0), dcache (1) and table walker (2). One transaction
//          at a time; responses go only to the granted requester; a hang
//          timeout turns a lost response into an err.
// Ports  : clk_i  clock
//          rst_i  asynchronous active-high reset
//          bus    thor2023_wb_arbiter_if.slave (req_i, resp_o, wbm_req,
//                 wbm_resp, grant_o, busy_o)
// Rev    : 1.0  initial release
// ============================================================================
module thor2023_wb_arbiter
  import thor2023_wb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TO_BITS = 11
) (
  input wire                    clk_i,
  input wire                    rst_i,
  thor2023_wb_arbiter_if.slave  bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_BITS-1:0] TO_ALL_ONES = '1;
  // The counter is 0 in the first granted cycle, so when it holds
  // all-ones minus one the count is about to reach all-ones: that is the
  // (2**TO_BITS-1)th silent cycle and the access is declared lost.
  localparam logic [TO_BITS-1:0] TO_FIRE = TO_ALL_ONES - 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DROP  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;

  logic                 pick_vld;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        idx_v;
  logic [GW-1:0]        gnt_inc;
  logic                 resp_any;
  wb_cmd_request128_t   cur_req;
  wb_cmd_request128_t   wbm_req_c;
  wb_cmd_response128_t  err_resp;
  wb_cmd_response128_t  [NREQ-1:0] resp_c;
  logic [NREQ-1:0]      grant_c;

  assign cur_req  = bus.req_i[gnt_q];
  assign resp_any = bus.wbm_resp.ack | bus.wbm_resp.rty | bus.wbm_resp.err;
  assign gnt_inc  = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + GW'(1);

  // First requester with cyc at or after rr_q, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx_v    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_v = GW'((int'(rr_q) + i) % NREQ);
      if (!pick_vld && bus.req_i[idx_v].cyc) begin
        pick_vld = 1'b1;
        pick     = idx_v;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick;
          state_d  = ST_GRANT;
          to_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A response outranks an abandon, which outranks the timeout
        if (resp_any) begin
          if (cur_req.cyc) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_IDLE;
            rr_d    = gnt_inc;
          end
        end else if (!cur_req.cyc) begin
          state_d = ST_IDLE;
          rr_d    = gnt_inc;
        end else if (to_cnt_q == TO_FIRE) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_DROP;
      end
      ST_DROP: begin
        if (!cur_req.cyc) begin
          state_d = ST_IDLE;
          rr_d    = gnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wbm_req_c    = '0;
    resp_c       = '0;
    grant_c      = '0;
    err_resp     = '0;
    err_resp.err = 1'b1;
    err_resp.tid = cur_req.tid;
    err_resp.cid = cur_req.cid;
    case (state_q)
      ST_GRANT: begin
        wbm_req_c      = cur_req;
        resp_c[gnt_q]  = bus.wbm_resp;
      end
      ST_ERR, ST_DROP: begin
        // Control forced low so a late-deasserting requester cannot start
        // a second access on the shared bus.
        wbm_req_c     = cur_req;
        wbm_req_c.cyc = 1'b0;
        wbm_req_c.stb = 1'b0;
        wbm_req_c.we  = 1'b0;
        wbm_req_c.sel = '0;
        if (state_q == ST_ERR) begin
          resp_c[gnt_q] = err_resp;
        end
      end
      default: begin
      end
    endcase
    if (state_q != ST_IDLE) begin
      grant_c[gnt_q] = 1'b1;
    end
  end

  assign bus.wbm_req = wbm_req_c;
  assign bus.resp_o  = resp_c;
  assign bus.grant_o = grant_c;
  assign bus.busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_thor2023_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_thor2023_wb_arbiter
// Purpose: Self-checking bench for thor2023_wb_arbiter: directed scenarios
//          with literal expectations plus randomized traffic compared every
//          cycle against a transaction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_thor2023_wb_arbiter;
  import thor2023_wb_pkg::*;

  localparam int NREQ    = 3;
  localparam int TO_BITS = 11;
  localparam int TIMEOUT = (1 << TO_BITS) - 1;  // silent granted cycles allowed

  // model phases of the single bus transaction
  localparam int M_FREE    = 0;
  localparam int M_OPEN    = 1;
  localparam int M_ERR     = 2;
  localparam int M_RELEASE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  thor2023_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  thor2023_wb_arbiter #(.NREQ(NREQ), .TO_BITS(TO_BITS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode  = M_FREE;
  int m_owner = 0;
  int m_age   = 0;   // granted cycles elapsed including the current one
  int m_turn  = 0;   // requester with first claim on the next grant

  always @(negedge clk) begin
    wb_cmd_request128_t  req_e;
    wb_cmd_response128_t rsp_e;
    logic [NREQ-1:0]     gnt_e;
    logic                got_resp;
    logic                own_cyc;
    if (rst) begin
      m_mode  = M_FREE;
      m_owner = 0;
      m_age   = 0;
      m_turn  = 0;
    end
    gnt_e = '0;
    if (m_mode != M_FREE) gnt_e[m_owner] = 1'b1;
    check("busy", 200'(bus.busy_o), 200'(m_mode != M_FREE));
    check("grant", 200'(bus.grant_o), 200'(gnt_e));
    if (m_mode == M_OPEN) begin
      check("wbm_req_pass", 200'(bus.wbm_req), 200'(bus.req_i[m_owner]));
    end else if (m_mode == M_FREE) begin
      check("wbm_req_idle", 200'(bus.wbm_req), 200'(0));
    end else begin
      check("wbm_req_forced",
            200'({bus.wbm_req.cyc, bus.wbm_req.stb, bus.wbm_req.we, bus.wbm_req.sel}), 200'(0));
    end
    for (int n = 0; n < NREQ; n++) begin
      rsp_e = '0;
      if (m_mode == M_OPEN && n == m_owner) begin
        rsp_e = bus.wbm_resp;
      end else if (m_mode == M_ERR && n == m_owner) begin
        rsp_e.err = 1'b1;
        rsp_e.tid = bus.req_i[n].tid;
        rsp_e.cid = bus.req_i[n].cid;
      end
      check($sformatf("resp%0d", n), 200'(bus.resp_o[n]), 200'(rsp_e));
    end
    if (!rst) begin
      got_resp = bus.wbm_resp.ack | bus.wbm_resp.rty | bus.wbm_resp.err;
      own_cyc  = bus.req_i[m_owner].cyc;
      req_e    = bus.req_i[m_owner];
      case (m_mode)
        M_FREE: begin
          for (int k = 0; k < NREQ; k++) begin
            if (m_mode == M_FREE && bus.req_i[(m_turn + k) % NREQ].cyc) begin
              m_owner = (m_turn + k) % NREQ;
              m_mode  = M_OPEN;
              m_age   = 0;
            end
          end
        end
        M_OPEN: begin
          m_age++;
          if (got_resp) begin
            if (own_cyc) m_mode = M_RELEASE;
            else begin m_mode = M_FREE; m_turn = (m_owner + 1) % NREQ; end
          end else if (!own_cyc) begin
            m_mode = M_FREE;
            m_turn = (m_owner + 1) % NREQ;
          end else if (m_age == TIMEOUT) begin
            m_mode = M_ERR;
          end
        end
        M_ERR: m_mode = M_RELEASE;
        default: begin
          if (!req_e.cyc) begin
            m_mode = M_FREE;
            m_turn = (m_owner + 1) % NREQ;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_i    = '0;
    bus.wbm_resp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_req(input int n);
    bus.req_i[n].cyc   = 1'b1;
    bus.req_i[n].stb   = 1'b1;
    bus.req_i[n].we    = 1'($urandom);
    bus.req_i[n].sel   = 16'($urandom);
    bus.req_i[n].vadr  = $urandom;
    bus.req_i[n].data1 = {$urandom, $urandom, $urandom, $urandom};
    bus.req_i[n].tid   = 8'($urandom);
    bus.req_i[n].cid   = 4'($urandom);
  endtask

  initial begin
    int seq[$];
    int gaps[$];
    int exp_seq[6];
    int age, gapc, owner, first_err, errc;
    logic [127:0] pat;

    clear_inputs();
    tick();
    tick();
    // reset state
    check("rst_grant", 200'(bus.grant_o), 200'(0));
    check("rst_busy", 200'(bus.busy_o), 200'(0));
    check("rst_wbm_req", 200'(bus.wbm_req), 200'(0));
    check("rst_resp", 200'(bus.resp_o), 200'(0));
    rst = 1'b0;

    // ---- single dcache read ----
    bus.req_i[1].cyc  = 1'b1;
    bus.req_i[1].stb  = 1'b1;
    bus.req_i[1].sel  = 16'hFFFF;
    bus.req_i[1].vadr = 32'h1000;
    tick();
    check("t1_grant", 200'(bus.grant_o), 200'(3'b010));
    check("t1_vadr", 200'(bus.wbm_req.vadr), 200'(32'h1000));
    check("t1_cyc", 200'(bus.wbm_req.cyc), 200'(1));
    pat = {16{8'hA5}};
    bus.wbm_resp.ack = 1'b1;
    bus.wbm_resp.dat = pat;
    #1;
    check("t1_ack", 200'(bus.resp_o[1].ack), 200'(1));
    check("t1_dat", 200'(bus.resp_o[1].dat), 200'(pat));
    check("t1_resp0", 200'(bus.resp_o[0]), 200'(0));
    check("t1_resp2", 200'(bus.resp_o[2]), 200'(0));
    tick();
    bus.wbm_resp = '0;
    bus.req_i[1].cyc = 1'b0;
    #1;
    check("t1_drop_grant", 200'(bus.grant_o), 200'(3'b010));
    check("t1_drop_cyc", 200'(bus.wbm_req.cyc), 200'(0));
    tick();

    // ---- all three requesting, ack on third granted cycle ----
    do_reset();
    for (int n = 0; n < NREQ; n++) rand_req(n);
    age = -1;
    gapc = 0;
    for (int c = 0; c < 80 && seq.size() < 6; c++) begin
      tick();
      bus.wbm_resp = '0;
      for (int n = 0; n < NREQ; n++) bus.req_i[n].cyc = 1'b1;
      #1;
      if (bus.grant_o != '0) begin
        owner = 0;
        for (int n = 0; n < NREQ; n++) if (bus.grant_o[n]) owner = n;
        if (age < 0) begin
          seq.push_back(owner);
          if (seq.size() > 1) gaps.push_back(gapc);
          gapc = 0;
          age = 0;
        end else begin
          age++;
        end
        if (age == 2) begin
          bus.wbm_resp.ack = 1'b1;
          bus.req_i[owner].cyc = 1'b0;
          age = -1;
        end
      end else begin
        gapc++;
      end
    end
    exp_seq = '{0, 1, 2, 0, 1, 2};
    check("rr_count", 200'(seq.size()), 200'(6));
    for (int i = 0; i < 6 && i < seq.size(); i++)
      check($sformatf("rr_seq%0d", i), 200'(seq[i]), 200'(exp_seq[i]));
    for (int i = 0; i < gaps.size(); i++)
      check($sformatf("rr_gap%0d", i), 200'(gaps[i]), 200'(1));
    clear_inputs();
    tick();
    tick();

    // ---- timeout on walker ----
    do_reset();
    rand_req(2);
    bus.req_i[2].tid = 8'h5A;
    bus.req_i[2].cid = 4'h3;
    first_err = -1;
    errc = 0;
    for (int c = 1; c <= 2055; c++) begin
      tick();
      if (bus.resp_o[2].err) begin
        errc++;
        if (first_err < 0) begin
          first_err = c;
          check("to_tid", 200'(bus.resp_o[2].tid), 200'(8'h5A));
          check("to_ack", 200'(bus.resp_o[2].ack), 200'(0));
          check("to_cyc", 200'(bus.wbm_req.cyc), 200'(0));
        end
      end
    end
    check("to_first_cycle", 200'(first_err), 200'(2048));
    check("to_err_pulses", 200'(errc), 200'(1));
    check("to_drop_busy", 200'(bus.busy_o), 200'(1));
    check("to_drop_grant", 200'(bus.grant_o), 200'(3'b100));
    bus.req_i[2].cyc = 1'b0;
    tick();
    check("to_idle", 200'(bus.busy_o), 200'(0));

    // ---- ack in the timeout cycle wins ----
    do_reset();
    rand_req(0);
    errc = 0;
    for (int c = 1; c <= 2060; c++) begin
      tick();
      bus.wbm_resp = '0;
      if (c == 2047) begin
        bus.wbm_resp.ack = 1'b1;
        #1;
        check("race_ack", 200'(bus.resp_o[0].ack), 200'(1));
      end
      if (bus.resp_o[0].err) errc++;
    end
    check("race_no_err", 200'(errc), 200'(0));
    clear_inputs();
    tick();
    tick();

    // ---- abandon, late ack, round-robin advance ----
    do_reset();
    rand_req(0);
    tick();
    bus.req_i[0].cyc = 1'b0;
    #1;
    check("ab_noresp", 200'(bus.resp_o), 200'(0));
    tick();
    check("ab_idle", 200'(bus.busy_o), 200'(0));
    bus.wbm_resp.ack = 1'b1;
    bus.wbm_resp.dat = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("ab_late_ack", 200'(bus.resp_o), 200'(0));
    tick();
    bus.wbm_resp = '0;
    for (int n = 0; n < NREQ; n++) rand_req(n);
    tick();
    check("ab_rr_next", 200'(bus.grant_o), 200'(3'b010));
    clear_inputs();
    tick();
    tick();

    // ---- asynchronous reset mid-grant ----
    rand_req(1);
    tick();
    check("ar_granted", 200'(bus.grant_o), 200'(3'b010));
    #1;
    rst = 1'b1;
    #1;
    check("ar_cyc", 200'(bus.wbm_req.cyc), 200'(0));
    check("ar_grant", 200'(bus.grant_o), 200'(0));
    check("ar_busy", 200'(bus.busy_o), 200'(0));
    clear_inputs();
    tick();
    rst = 1'b0;

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int n = 0; n < NREQ; n++) begin
        if (bus.req_i[n].cyc) begin
          if ($urandom_range(0, 7) == 0) bus.req_i[n].cyc = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rand_req(n);
        end
      end
      bus.wbm_resp     = '0;
      bus.wbm_resp.dat = {$urandom, $urandom, $urandom, $urandom};
      bus.wbm_resp.tid = 8'($urandom);
      bus.wbm_resp.cid = 4'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: bus.wbm_resp.ack = 1'b1;
        3:       bus.wbm_resp.rty = 1'b1;
        4:       bus.wbm_resp.err = 1'b1;
        default: ;
      endcase
    end
    clear_inputs();
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
